// File: rtl/trap_sequencer.sv
// trap_sequencer: owns the single csr_file port during trap entry and mret
// return, and passes pipeline CSR accesses through while idle.
module trap_sequencer #(
    parameter bit         VECTORED_EN = 1'b1,
    parameter logic [2:0] IRQ_MASK    = 3'b111   // {ext, timer, soft}
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    // pipeline CSR port
    input  logic        inst_csr_req,
    input  logic [11:0] inst_csr_addr,
    input  logic [31:0] inst_csr_wdata,
    input  logic        inst_csr_wen,
    output logic        inst_csr_ready,
    output logic [31:0] inst_csr_rdata,
    // trap / return requests
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_valid,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    input  logic [31:0] irq_pc,
    output logic        trap_ack,
    // csr_file port
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_wen,
    input  logic [31:0] csr_rdata,
    input  logic        csr_mie,
    // fetch redirect
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [3:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, R_TVEC, M_STAT, M_EPC, REDIR
    } state_t;

    state_t      state, state_n;
    logic        is_irq_q;
    logic [3:0]  cause_q;
    logic [31:0] pc_q, tval_q, target_q;

    logic [2:0]  irq_masked;
    logic [3:0]  irq_cause;
    logic        take_exc, take_mret, take_irq, accept;
    logic [31:0] tvec_base, tvec_target;

    assign inst_csr_rdata = csr_rdata;
    assign redirect_pc    = target_q;
    assign busy           = (state != IDLE);

    // Acceptance decode: exception beats mret beats interrupt; ext > soft > timer.
    always_comb begin
        irq_masked = {irq_ext, irq_timer, irq_soft} & IRQ_MASK;
        irq_cause  = irq_masked[2] ? 4'd11 : (irq_masked[0] ? 4'd3 : 4'd7);
        take_exc   = ctrl_reset_n && (state == IDLE) && exc_valid;
        take_mret  = ctrl_reset_n && (state == IDLE) && !exc_valid && mret_valid;
        take_irq   = ctrl_reset_n && (state == IDLE) && !exc_valid && !mret_valid
                     && csr_mie && (|irq_masked);
        accept     = take_exc || take_mret || take_irq;
    end

    // Trap vector: vectored mode only applies to interrupts; wraps mod 2^32.
    always_comb begin
        tvec_base   = csr_rdata & ~32'h3;
        tvec_target = tvec_base;
        if (VECTORED_EN && (csr_rdata[1:0] == 2'b01) && is_irq_q)
            tvec_target = tvec_base + {26'b0, cause_q, 2'b00};
    end

    // Next state and csr_file port drive; one CSR operation per sequence state.
    always_comb begin
        state_n        = state;
        inst_csr_ready = 1'b0;
        csr_addr       = 12'h000;
        csr_wdata      = 32'h0;
        csr_wen        = 1'b0;
        trap_ack       = 1'b0;
        redirect_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // the accepting cycle blocks the pipeline's access entirely
                    trap_ack = 1'b1;
                    state_n  = take_mret ? M_STAT : W_EPC;
                end else begin
                    csr_addr       = inst_csr_addr;
                    csr_wdata      = inst_csr_wdata;
                    csr_wen        = ctrl_reset_n && inst_csr_req && inst_csr_wen;
                    inst_csr_ready = ctrl_reset_n && inst_csr_req;
                end
            end
            W_EPC: begin
                csr_addr  = A_MEPC;
                csr_wdata = {pc_q[31:2], 2'b00};
                csr_wen   = 1'b1;
                state_n   = W_CAUSE;
            end
            W_CAUSE: begin
                csr_addr  = A_MCAUSE;
                csr_wdata = {is_irq_q, 27'b0, cause_q};
                csr_wen   = 1'b1;
                state_n   = W_TVAL;
            end
            W_TVAL: begin
                csr_addr  = A_MTVAL;
                csr_wdata = tval_q;
                csr_wen   = 1'b1;
                state_n   = W_STAT;
            end
            W_STAT: begin
                // MPIE <= MIE, MIE <= 0
                csr_addr  = A_MSTATUS;
                csr_wdata = {csr_rdata[31:8], csr_rdata[3], csr_rdata[6:4], 1'b0, csr_rdata[2:0]};
                csr_wen   = 1'b1;
                state_n   = R_TVEC;
            end
            R_TVEC: begin
                csr_addr = A_MTVEC;
                state_n  = REDIR;
            end
            M_STAT: begin
                // MIE <= MPIE, MPIE <= 1
                csr_addr  = A_MSTATUS;
                csr_wdata = {csr_rdata[31:8], 1'b1, csr_rdata[6:4], csr_rdata[7], csr_rdata[2:0]};
                csr_wen   = 1'b1;
                state_n   = M_EPC;
            end
            M_EPC: begin
                csr_addr = A_MEPC;
                state_n  = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) state <= IDLE;
        else               state <= state_n;
    end

    // Latch trap context on acceptance; capture the jump target from csr_file.
    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            is_irq_q <= 1'b0;
            cause_q  <= 4'h0;
            pc_q     <= 32'h0;
            tval_q   <= 32'h0;
            target_q <= 32'h0;
        end else begin
            if (take_exc) begin
                is_irq_q <= 1'b0;
                cause_q  <= exc_cause;
                pc_q     <= exc_pc;
                tval_q   <= exc_tval;
            end else if (take_irq) begin
                is_irq_q <= 1'b1;
                cause_q  <= irq_cause;
                pc_q     <= irq_pc;
                tval_q   <= 32'h0;
            end
            if (state == R_TVEC) target_q <= tvec_target;
            if (state == M_EPC)  target_q <= csr_rdata;
        end
    end

endmodule
